apb_req_sched: RTL and testbench

APB_REQ_SCHED -- requirements
Module: apb_req_sched

---
 rtl/apb_sched_pkg.sv | 17 +
 rtl/apb_req_sched_rr_arb2.sv | 37 +++
 rtl/apb_req_sched.sv | 177 +++++++++++++++++
 tb/tb_apb_req_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_sched_pkg.sv
// Shared definitions for the two-requester APB scheduler: FSM state
// encoding and the default interface widths.
package apb_sched_pkg;

  // Default widths and wait limit used by apb_req_sched parameters
  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int STRB_W_DEF  = 2;
  localparam int TIMEOUT_DEF = 255;

  // Scheduler FSM state type and encodings
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETUP  = 2'd1;
  localparam state_t ST_ACCESS = 2'd2;

endpackage

// File: rtl/apb_req_sched_rr_arb2.sv
// Two-way round-robin arbiter. Grant is one-hot and combinational from the
// valids; the "last served" pointer moves only when the caller strobes
// i_advance (a transfer was actually taken).
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_valid,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  // 1 means requester 1 was served last, so requester 0 wins the next tie
  logic r_last;

  // Grant selection: single requester wins outright, a tie goes to the other one
  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  // Pointer update; reset leaves requester 0 favoured
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (i_advance) begin
      r_last <= o_grant[1];
    end else begin
      r_last <= r_last;
    end
  end

endmodule

// File: rtl/apb_req_sched.sv
// Two-requester APB scheduler: arbitrates between two request ports, runs
// one APB transfer at a time (IDLE -> SETUP -> ACCESS) with an ACCESS-phase
// timeout, and returns a one-cycle completion pulse tagged with the owner.
module apb_req_sched
  import apb_sched_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int STRB_W  = STRB_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  input  logic [2*STRB_W-1:0] req_strb,
  output logic                rsp_valid,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [STRB_W-1:0]   pstrb,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Counter value in the last ACCESS cycle before the timeout fires
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t              r_state;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic [STRB_W-1:0]   r_pstrb;
  logic                r_id;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_rsp_valid;
  logic                r_rsp_id;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;

  logic [1:0]          w_grant;
  logic                w_accept;
  logic                w_sel;
  logic                w_wr;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [STRB_W-1:0]   w_strb;

  rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (req_valid),
    .i_advance (w_accept),
    .o_grant   (w_grant)
  );

  // Ready only in IDLE and only toward the granted, valid requester
  assign req_ready = ((r_state == ST_IDLE) && !reset) ? (w_grant & req_valid) : 2'b00;
  assign w_accept  = |req_ready;
  assign w_sel     = w_grant[1];

  // Field mux for the requester being accepted
  always_comb begin
    w_wr    = req_write[0];
    w_addr  = req_addr[ADDR_W-1:0];
    w_wdata = req_wdata[DATA_W-1:0];
    w_strb  = req_strb[STRB_W-1:0];
    if (w_sel) begin
      w_wr    = req_write[1];
      w_addr  = req_addr[2*ADDR_W-1:ADDR_W];
      w_wdata = req_wdata[2*DATA_W-1:DATA_W];
      w_strb  = req_strb[2*STRB_W-1:STRB_W];
    end else begin
      w_wr    = req_write[0];
      w_addr  = req_addr[ADDR_W-1:0];
      w_wdata = req_wdata[DATA_W-1:0];
      w_strb  = req_strb[STRB_W-1:0];
    end
  end

  // Transfer FSM, APB bus registers, timeout counter and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_id        <= 1'b0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state   <= ST_SETUP;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_pwrite  <= w_wr;
            r_paddr   <= w_addr;
            r_pwdata  <= w_wdata;
            // Reads drive no byte lanes
            r_pstrb   <= w_wr ? w_strb : '0;
            r_id      <= w_sel;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          r_state   <= ST_ACCESS;
          r_penable <= 1'b1;
          r_cnt     <= '0;
        end
        ST_ACCESS: begin
          if (pready) begin
            // Completer answered; wins even in the cycle the timeout would fire
            r_state     <= ST_IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_rdata <= r_pwrite ? '0 : prdata;
            r_rsp_err   <= pslverr;
          end else if (r_cnt == TO_LAST) begin
            // Completer never answered: close the transfer with an error
            r_state     <= ST_IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign pstrb     = r_pstrb;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_req_sched.sv
// Self-checking bench for apb_req_sched: a table of single-requester
// transfers plus hand-written sequences for arbitration, reset abort and
// stray completer signalling. Expected responses go through a scoreboard.
module tb_apb_req_sched;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [2*SW-1:0] req_strb;
  logic          rsp_valid;
  logic          rsp_id;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  always #5 clk = ~clk;

  apb_req_sched #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    logic        id;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  strb;
    int          wait_n;     // ACCESS cycles with pready=0 before pready=1
    logic [31:0] prd;
    logic        slv;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every completion pulse must match the oldest expected response
  always @(negedge clk) begin : mon
    rsp_t e;
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_rsp", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_id", 64'(rsp_id), 64'(e.id));
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
  end

  task automatic idle_inputs();
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_xfer(input vec_t v);
    logic [1:0] exp_strb;
    rsp_t e;
    exp_strb = v.wr ? v.strb : 2'b00;
    @(negedge clk);
    check("rsp_one_cycle", 64'(rsp_valid), 64'd0);
    req_valid = v.id ? 2'b10 : 2'b01;
    req_write = v.id ? {v.wr, ~v.wr} : {~v.wr, v.wr};
    req_addr  = v.id ? {v.addr, 32'h0BAD0BAD} : {32'h0BAD0BAD, v.addr};
    req_wdata = v.id ? {v.wdata, 32'h77777777} : {32'h77777777, v.wdata};
    req_strb  = v.id ? {v.strb, ~v.strb} : {~v.strb, v.strb};
    #1;
    check("req_ready", 64'(req_ready), v.id ? 64'd2 : 64'd1);
    @(negedge clk);
    // Scramble inputs after acceptance; the bus must keep the latched values
    req_valid = 2'b00;
    req_write = ~req_write;
    req_addr  = ~req_addr;
    req_wdata = ~req_wdata;
    req_strb  = ~req_strb;
    #1;
    check("setup_ctl", 64'({psel, penable}), 64'd2);
    check("setup_ready", 64'(req_ready), 64'd0);
    check("setup_pwrite", 64'(pwrite), 64'(v.wr));
    check("setup_paddr", 64'(paddr), 64'(v.addr));
    check("setup_pstrb", 64'(pstrb), 64'(exp_strb));
    if (v.wr) check("setup_pwdata", 64'(pwdata), 64'(v.wdata));
    e.id = v.id; e.rdata = v.exp_rdata; e.err = v.exp_err;
    sb.push_back(e);
    for (int n = 0; n < TO; n++) begin
      @(negedge clk);
      check("access_ctl", 64'({psel, penable}), 64'd3);
      check("access_paddr", 64'(paddr), 64'(v.addr));
      check("access_pwrite", 64'(pwrite), 64'(v.wr));
      check("access_pstrb", 64'(pstrb), 64'(exp_strb));
      pready  = (n == v.wait_n);
      prdata  = pready ? v.prd : 32'h5555AAAA;
      pslverr = pready ? v.slv : 1'b1;
      if (n == v.wait_n) break;
    end
    @(negedge clk);
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    check("rsp_pulse_ctl", 64'({rsp_valid, psel, penable}), 64'd4);
  endtask

  vec_t vecs[7];

  initial begin
    idle_inputs();
    reset = 1'b1;
    req_valid = 2'b11;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_ctl", 64'({psel, penable, pwrite, rsp_valid, rsp_id, rsp_err}), 64'd0);
    check("rst_fields", 64'({paddr, pstrb}), 64'd0);
    check("rst_data", 64'({pwdata, rsp_rdata}), 64'd0);
    req_valid = 2'b00;
    reset = 1'b0;

    //           id    wr    addr          wdata         strb   wait prd           slv   err   rdata
    vecs[0] = '{1'b0, 1'b1, 32'h12345566, 32'hA5A5A5A5, 2'b11, 0,   32'h0,        1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h00001000, 32'h11111111, 2'b11, 4,   32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b0, 32'h00002000, 32'h0,        2'b10, 99,  32'hCAFEF00D, 1'b0, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 32'h00003000, 32'h01020304, 2'b01, 0,   32'h99999999, 1'b1, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 32'h00004000, 32'h0,        2'b01, 2,   32'h00001234, 1'b1, 1'b1, 32'h00001234};
    vecs[5] = '{1'b1, 1'b0, 32'h00005000, 32'h0,        2'b00, 7,   32'h87654321, 1'b0, 1'b0, 32'h87654321};
    vecs[6] = '{1'b0, 1'b1, 32'h00006000, 32'hFFFF0000, 2'b01, 1,   32'hAAAAAAAA, 1'b0, 1'b0, 32'h0};
    for (int i = 0; i < 7; i++) run_xfer(vecs[i]);

    // Stray completer signalling while IDLE must not start or finish anything
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      pready = 1'b1; pslverr = 1'b1; prdata = 32'hBADBAD00;
      #1;
      check("stray_idle", 64'({psel, penable, rsp_valid}), 64'd0);
    end
    @(negedge clk);
    check("stray_after", 64'({psel, penable, rsp_valid}), 64'd0);
    idle_inputs();

    // Both requesters held valid from reset: grants alternate 0,1,0,1
    do_reset();
    @(negedge clk);
    req_valid = 2'b11;
    req_write = 2'b11;
    req_addr  = {32'h0000B000, 32'h0000A000};
    req_wdata = {32'h22222222, 32'h11111111};
    req_strb  = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      rsp_t e;
      #1;
      check("rr_ready", 64'(req_ready), (k % 2) ? 64'd2 : 64'd1);
      e.id = 1'(k % 2); e.rdata = 32'h0; e.err = 1'b0;
      sb.push_back(e);
      @(negedge clk);
      check("rr_paddr", 64'(paddr), (k % 2) ? 64'h0000B000 : 64'h0000A000);
      @(negedge clk);
      pready = 1'b1;
      @(negedge clk);
      pready = 1'b0;
      check("rr_back_to_back", 64'(rsp_valid), 64'd1);
    end
    req_valid = 2'b00;

    // Reset during ACCESS aborts without a response; tie then goes to req0
    @(negedge clk);
    req_valid = 2'b01;
    req_write = 2'b00;
    req_addr  = {32'h0, 32'h0000C000};
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    check("abort_in_access", 64'({psel, penable}), 64'd3);
    reset  = 1'b1;
    pready = 1'b1;
    prdata = 32'h12121212;
    @(negedge clk);
    check("abort_ctl", 64'({psel, penable, pwrite, rsp_valid, rsp_err}), 64'd0);
    check("abort_fields", 64'({paddr, pstrb}), 64'd0);
    reset  = 1'b0;
    pready = 1'b0;
    prdata = '0;
    req_valid = 2'b11;
    #1;
    check("tie_after_reset", 64'(req_ready), 64'd1);
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("abort_no_rsp", 64'({rsp_valid, psel}), 64'd0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
